// File: rtl/uart_param_if.sv
// uart_param_if: serial pins plus the byte-stream handshake of uart_param.
//   master : the user side (drives rx line, enables, tx requests; sees rx results, tx line/status)
//   slave  : the UART itself
// Ports carried: rx, rxEn, rxData, rxValid, rxBusy, rxFrameErr, rxParityErr,
//                tx, txEn, txStart, txData, txDone, txBusy.
interface uart_param_if #(parameter int DATA_BITS = 8);
  logic                 rx;
  logic                 rxEn;
  logic [DATA_BITS-1:0] rxData;
  logic                 rxValid;
  logic                 rxBusy;
  logic                 rxFrameErr;
  logic                 rxParityErr;
  logic                 tx;
  logic                 txEn;
  logic                 txStart;
  logic [DATA_BITS-1:0] txData;
  logic                 txDone;
  logic                 txBusy;

  modport master (
    output rx, rxEn, txEn, txStart, txData,
    input  rxData, rxValid, rxBusy, rxFrameErr, rxParityErr, tx, txDone, txBusy
  );

  modport slave (
    input  rx, rxEn, txEn, txStart, txData,
    output rxData, rxValid, rxBusy, rxFrameErr, rxParityErr, tx, txDone, txBusy
  );
endinterface

// File: rtl/uart_param.sv
// uart_param: single-clock UART with parameterised frame format
// (DATA_BITS data, optional odd/even parity, STOP_BITS stop bits).
// Bit timing is derived from cycle counters: BIT_CLKS = CLOCK_RATE/BAUD_RATE.
// Ports:
//   clk  - system clock, rising edge
//   rstN - synchronous active-low reset
//   bus  - uart_param_if.slave (serial pins, rx results, tx request/status)
module uart_param #(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS  = 1
) (
  input  logic         clk,
  input  logic         rstN,
  uart_param_if.slave  bus
);
  localparam int BIT_CLKS = CLOCK_RATE / BAUD_RATE;
  localparam int CW       = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] TICK      = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(BIT_CLKS / 2 - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------- receiver ----------------
  logic                 rx_meta_q, rxS_q, rxS_prev_q;
  state_e               rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic                 rx_par_q, rx_par_d;       // running XOR of data bits
  logic                 rx_perr_q, rx_perr_d;     // parity result held until stop
  logic                 rx_ferr_q, rx_ferr_d, rx_perr_o_q, rx_perr_o_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_tick;

  assign rx_tick = (rx_cnt_q == TICK);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_par_d    = rx_par_q;
    rx_perr_d   = rx_perr_q;
    rx_data_d   = rx_data_q;
    rx_ferr_d   = rx_ferr_q;
    rx_perr_o_d = rx_perr_o_q;
    rx_valid_d  = 1'b0;
    case (rx_state_q)
      S_IDLE: if (bus.rxEn && rxS_prev_q && !rxS_q) begin
        rx_state_d = S_START;
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_par_d   = 1'b0;
        rx_perr_d  = 1'b0;
      end
      // Mid-bit check of the start bit; a high line here was a glitch.
      S_START: if (rx_cnt_q == HALF_M1) begin
        rx_cnt_d   = '0;
        rx_state_d = rxS_q ? S_IDLE : S_DATA;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      S_DATA: if (rx_tick) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rxS_q, rx_sh_q[DATA_BITS-1:1]};  // LSB arrives first
        rx_par_d = rx_par_q ^ rxS_q;
        rx_bit_d = rx_bit_q + 4'd1;
        if (rx_bit_q == LAST_BIT) rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      S_PARITY: if (rx_tick) begin
        rx_cnt_d   = '0;
        rx_perr_d  = (PARITY == 1) ? ~(rx_par_q ^ rxS_q) : (rx_par_q ^ rxS_q);
        rx_state_d = S_STOP;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      S_STOP: if (rx_tick) begin
        rx_cnt_d    = '0;
        rx_state_d  = S_IDLE;
        rx_data_d   = rx_sh_q;
        rx_ferr_d   = ~rxS_q;
        rx_perr_o_d = rx_perr_q;
        rx_valid_d  = 1'b1;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      default: rx_state_d = S_IDLE;
    endcase
    // Disabling drops the frame without touching the published result.
    if (!bus.rxEn) begin
      rx_state_d  = S_IDLE;
      rx_cnt_d    = '0;
      rx_data_d   = rx_data_q;
      rx_ferr_d   = rx_ferr_q;
      rx_perr_o_d = rx_perr_o_q;
      rx_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      rx_meta_q   <= 1'b1;  // idle-high so reset release is not seen as a start edge
      rxS_q       <= 1'b1;
      rxS_prev_q  <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_par_q    <= 1'b0;
      rx_perr_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_ferr_q   <= 1'b0;
      rx_perr_o_q <= 1'b0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_meta_q   <= bus.rx;
      rxS_q       <= rx_meta_q;
      rxS_prev_q  <= rxS_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_par_q    <= rx_par_d;
      rx_perr_q   <= rx_perr_d;
      rx_data_q   <= rx_data_d;
      rx_ferr_q   <= rx_ferr_d;
      rx_perr_o_q <= rx_perr_o_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign bus.rxData      = rx_data_q;
  assign bus.rxValid     = rx_valid_q;
  assign bus.rxBusy      = (rx_state_q != S_IDLE);
  assign bus.rxFrameErr  = rx_ferr_q;
  assign bus.rxParityErr = rx_perr_o_q;

  // ---------------- transmitter ----------------
  state_e               tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;   // parity bit to send
  logic                 tx_stop_q, tx_stop_d;
  logic                 tx_q, tx_d;
  logic                 tx_tick;

  assign tx_tick = (tx_cnt_q == TICK);

  // tx_q holds the current line level; it only changes on bit boundaries.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    tx_d       = tx_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (bus.txStart && bus.txEn) begin
          tx_state_d = S_START;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_stop_d  = 1'b0;
          tx_sh_d    = bus.txData;
          tx_par_d   = (PARITY == 1) ? ~(^bus.txData) : ^bus.txData;
          tx_d       = 1'b0;
        end
      end
      S_START: if (tx_tick) begin
        tx_cnt_d   = '0;
        tx_state_d = S_DATA;
        tx_d       = tx_sh_q[0];
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      S_DATA: if (tx_tick) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 4'd1;
        tx_sh_d  = {1'b0, tx_sh_q[DATA_BITS-1:1]};
        if (tx_bit_q == LAST_BIT) begin
          if (PARITY != 0) begin
            tx_state_d = S_PARITY;
            tx_d       = tx_par_q;
          end else begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end
        end else tx_d = tx_sh_q[1];
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      S_PARITY: if (tx_tick) begin
        tx_cnt_d   = '0;
        tx_state_d = S_STOP;
        tx_d       = 1'b1;
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      S_STOP: if (tx_tick) begin
        tx_cnt_d = '0;
        if (tx_stop_q == LAST_STOP) tx_state_d = S_IDLE;
        else tx_stop_d = 1'b1;
        tx_d = 1'b1;
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_stop_q  <= tx_stop_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.tx     = tx_q;
  assign bus.txBusy = (tx_state_q != S_IDLE);
  assign bus.txDone = (tx_state_q == S_STOP) && tx_tick && (tx_stop_q == LAST_STOP);
endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: three uart_param instances (8E1 loopback, 8O1 driven rx, 7N2 loopback),
// all at BIT_CLKS=10. Expected rx words go into per-instance queues when stimulus is
// driven and are popped when rxValid pulses.
module tb_uart_param;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_param_if #(.DATA_BITS(8)) if8e ();
  uart_param_if #(.DATA_BITS(8)) if8o ();
  uart_param_if #(.DATA_BITS(7)) if7n ();

  uart_param #(.CLOCK_RATE(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u8e (.clk(clk), .rstN(rstN), .bus(if8e.slave));
  uart_param #(.CLOCK_RATE(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    u8o (.clk(clk), .rstN(rstN), .bus(if8o.slave));
  uart_param #(.CLOCK_RATE(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
    u7n (.clk(clk), .rstN(rstN), .bus(if7n.slave));

  assign if8e.rx = if8e.tx;
  assign if7n.rx = if7n.tx;

  typedef struct packed {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t q8e[$], q8o[$], q7n[$];
  exp_t e8e, e8o, e7n;
  int v8e = 0, v8o = 0, v7n = 0;   // rxValid pulses seen
  int d8e = 0;                     // txDone pulses seen on 8E1
  int rxv8e_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboards ----------------
  always @(negedge clk) if (if8e.txDone) d8e++;

  always @(negedge clk) if (if8e.rxValid) begin
    v8e++;
    rxv8e_cyc = cyc;
    chk("8e_valid_expected", (q8e.size() != 0), 1);
    if (q8e.size() != 0) begin
      e8e = q8e.pop_front();
      chk("8e_rxData", if8e.rxData, e8e.data);
      chk("8e_ferr", if8e.rxFrameErr, e8e.ferr);
      chk("8e_perr", if8e.rxParityErr, e8e.perr);
    end
  end

  always @(negedge clk) if (if8o.rxValid) begin
    v8o++;
    chk("8o_valid_expected", (q8o.size() != 0), 1);
    if (q8o.size() != 0) begin
      e8o = q8o.pop_front();
      chk("8o_rxData", if8o.rxData, e8o.data);
      chk("8o_ferr", if8o.rxFrameErr, e8o.ferr);
      chk("8o_perr", if8o.rxParityErr, e8o.perr);
    end
  end

  always @(negedge clk) if (if7n.rxValid) begin
    v7n++;
    chk("7n_valid_expected", (q7n.size() != 0), 1);
    if (q7n.size() != 0) begin
      e7n = q7n.pop_front();
      chk("7n_rxData", if7n.rxData, e7n.data);
      chk("7n_ferr", if7n.rxFrameErr, e7n.ferr);
      chk("7n_perr", if7n.rxParityErr, e7n.perr);
    end
  end

  // ---------------- helpers ----------------
  // 8E1 line bits in time order: start, d[0..7], even parity, stop.
  function automatic logic [10:0] frame8e(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  // Send one word on 8E1 and check waveform, txDone/txBusy timing and rx latency.
  // With poke set, txStart/txData are disturbed mid-frame and txEn is dropped.
  task automatic tx8e_frame(input logic [7:0] d, input bit poke);
    int done_c;
    int cn;
    int d0;
    logic [10:0] s;
    @(negedge clk);
    if8e.txData = d; if8e.txStart = 1'b1; if8e.txEn = 1'b1;
    cn = cyc; d0 = d8e; done_c = 0; s = '1;
    q8e.push_back('{data: {1'b0, d}, ferr: 1'b0, perr: 1'b0});
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if8e.txStart = 1'b0;
        chk("8e_start_low", if8e.tx, 0);
        chk("8e_busy_rise", if8e.txBusy, 1);
      end
      if (poke) begin
        if (c == 30) begin if8e.txStart = 1'b1; if8e.txData = 8'hFF; end
        if (c == 33) if8e.txStart = 1'b0;
        if (c == 50) if8e.txEn = 1'b0;
      end
      if (((c - 1) % 10 == 5) && ((c - 1) / 10 < 11)) s[(c - 1) / 10] = if8e.tx;
      if (done_c != 0 && c == done_c + 1) chk("8e_busy_fall", if8e.txBusy, 0);
      if (if8e.txDone && done_c == 0) done_c = c;
    end
    chk("8e_tx_bits", s, frame8e(d));
    chk("8e_done_cycle", done_c, 110);
    chk("8e_done_count", d8e - d0, 1);
    chk("8e_rx_latency", rxv8e_cyc - cn, 109);
    if8e.txEn = 1'b1;
  endtask

  // Drive one 8O1 frame on rx. abort_bit >= 0 drops rxEn inside that bit.
  task automatic send8o(input logic [7:0] d, input logic pbit, input logic stopb, input int abort_bit);
    logic [10:0] f;
    logic good_p;
    f = {stopb, pbit, d, 1'b0};
    good_p = ~(^d);
    if (abort_bit < 0)
      q8o.push_back('{data: {1'b0, d}, ferr: ~stopb, perr: (pbit != good_p)});
    for (int k = 0; k < 11; k++) begin
      if8o.rx = f[k];
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if (k == abort_bit && j == 2) begin
          chk("8o_busy_mid", if8o.rxBusy, 1);
          if8o.rxEn = 1'b0;
        end
        if (k == abort_bit && j == 3) chk("8o_abort_busy", if8o.rxBusy, 0);
      end
    end
    if8o.rx = 1'b1;
    repeat (20) @(negedge clk);
    if8o.rxEn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int first, second, v0;
    logic fe0;
    if8e.rxEn = 1'b1; if8e.txEn = 1'b0; if8e.txStart = 1'b0; if8e.txData = '0;
    if8o.rx = 1'b1; if8o.rxEn = 1'b1; if8o.txEn = 1'b0; if8o.txStart = 1'b0; if8o.txData = '0;
    if7n.rxEn = 1'b1; if7n.txEn = 1'b0; if7n.txStart = 1'b0; if7n.txData = '0;
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", if8e.tx, 1);
    chk("rst_txBusy", if8e.txBusy, 0);
    chk("rst_txDone", if8e.txDone, 0);
    chk("rst_rxData", if8e.rxData, 0);
    chk("rst_rxValid", if8e.rxValid, 0);
    chk("rst_rxBusy", if8e.rxBusy, 0);
    chk("rst_ferr", if8e.rxFrameErr, 0);
    chk("rst_perr", if8e.rxParityErr, 0);
    rstN = 1'b1;
    repeat (5) @(negedge clk);

    // 8E1 loopback of 0xA5
    tx8e_frame(8'hA5, 1'b0);

    // txStart with txEn=0 is ignored
    v0 = d8e;
    if8e.txEn = 1'b0; if8e.txStart = 1'b1; if8e.txData = 8'h33;
    repeat (6) @(negedge clk);
    chk("8e_dis_busy", if8e.txBusy, 0);
    chk("8e_dis_tx", if8e.tx, 1);
    if8e.txStart = 1'b0; if8e.txEn = 1'b1;
    repeat (3) @(negedge clk);
    chk("8e_dis_done", d8e - v0, 0);

    // txStart while busy / txEn dropped mid-frame
    tx8e_frame(8'h3C, 1'b1);

    // glitch rejection on 8O1 rx
    v0 = v8o;
    first = 0;
    if8o.rx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if8o.rxBusy) first = 1;
    end
    if8o.rx = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if8o.rxBusy) first = 1;
    end
    chk("glitch_busy_seen", first, 1);
    chk("glitch_busy_clear", if8o.rxBusy, 0);
    chk("glitch_no_valid", v8o - v0, 0);
    repeat (5) @(negedge clk);

    // parity / framing errors on 8O1
    send8o(8'h0F, 1'b0, 1'b1, -1);   // wrong odd parity
    send8o(8'h0F, 1'b1, 1'b1, -1);   // correct odd parity
    send8o(8'h3C, 1'b1, 1'b0, -1);   // good parity, stop forced low
    chk("8o_err_valids", v8o - v0, 3);

    // rxEn dropped mid-frame: nothing published, flags kept
    v0 = v8o;
    fe0 = if8o.rxFrameErr;
    send8o(8'h81, 1'b1, 1'b1, 3);
    chk("8o_abort_no_valid", v8o - v0, 0);
    chk("8o_abort_flag_kept", if8o.rxFrameErr, fe0);
    send8o(8'h5A, 1'b1, 1'b1, -1);
    chk("8o_after_abort_valid", v8o - v0, 1);

    // 7N2: 100-cycle frame, then back-to-back with txStart held
    @(negedge clk);
    if7n.txData = 7'h55; if7n.txStart = 1'b1; if7n.txEn = 1'b1;
    q7n.push_back('{data: 9'h055, ferr: 1'b0, perr: 1'b0});
    q7n.push_back('{data: 9'h055, ferr: 1'b0, perr: 1'b0});
    first = 0; second = 0;
    for (int c = 1; c <= 260; c++) begin
      @(negedge clk);
      if (first != 0 && c == first + 1) begin
        chk("7n_gap_tx", if7n.tx, 1);
        chk("7n_gap_busy", if7n.txBusy, 0);
      end
      if (first != 0 && c == first + 2) begin
        chk("7n_second_start", if7n.tx, 0);
        chk("7n_second_busy", if7n.txBusy, 1);
        if7n.txStart = 1'b0;
      end
      if (if7n.txDone) begin
        if (first == 0) first = c;
        else if (second == 0) second = c;
      end
    end
    chk("7n_frame_len", first, 100);
    chk("7n_second_done", second - first, 101);
    chk("7n_rx_count", v7n, 2);

    // reset in the middle of a tx data bit
    v0 = v8e;
    @(negedge clk);
    if8e.txData = 8'h00; if8e.txStart = 1'b1;
    @(negedge clk);
    if8e.txStart = 1'b0;
    repeat (34) @(negedge clk);
    chk("8e_busy_before_rst", if8e.txBusy, 1);
    rstN = 1'b0;
    @(negedge clk);
    chk("midrst_tx", if8e.tx, 1);
    chk("midrst_txBusy", if8e.txBusy, 0);
    chk("midrst_rxBusy", if8e.rxBusy, 0);
    chk("midrst_8o_rxData", if8o.rxData, 0);
    rstN = 1'b1;
    repeat (150) @(negedge clk);
    chk("midrst_no_valid", v8e - v0, 0);
    chk("midrst_no_done_busy", if8e.txBusy, 0);

    chk("q8e_drained", q8e.size(), 0);
    chk("q8o_drained", q8o.size(), 0);
    chk("q7n_drained", q7n.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
